mem_stage: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline. It sits between the EX stage (ALU result, store data, control) and the register-file writeback.
- Owns the data RAM and implements lb/lh/lw/lbu/lhu/sb/sh/sw with byte lanes, sign/zero extension and misalignment detection.
- Registers the MEM/WB pipeline boundary.
- Clears the RAM after reset and exposes a debug read port for the seg7 display mux.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/load_align.sv | 47 ++++
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, FSM states and lane geometry.
package mem_stage_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic {
    MS_CLEAR = 1'b0,
    MS_RUN   = 1'b1
  } ms_state_e;

endpackage

// File: rtl/load_align.sv
// Extracts and sign/zero-extends the addressed byte/halfword of a RAM word; flags bad alignment.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data     = word;
    misalign = 1'b0;
    case (funct3)
      FUNCT3_LB:  data = {{24{b[7]}}, b};
      FUNCT3_LBU: data = {24'h0, b};
      FUNCT3_LH: begin
        data     = {{16{h[15]}}, h};
        misalign = off[0];
      end
      FUNCT3_LHU: begin
        data     = {16'h0, h};
        misalign = off[0];
      end
      FUNCT3_LW:  misalign = |off;
      // funct3 3/6/7 are not loads in RV32I; reported through the misalign path
      default:    misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: owns the data RAM, performs byte-lane loads/stores and registers MEM/WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_flush,
  input  logic [31:0]   ex_alu,
  input  logic [31:0]   ex_store_data,
  input  logic [2:0]    ex_funct3,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_reg_write,
  input  logic [4:0]    ex_rd,
  input  logic          wb_stall,
  output logic          wb_valid,
  output logic          wb_reg_write,
  output logic [4:0]    wb_rd,
  output logic [31:0]   wb_data,
  output logic          wb_exc,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data,
  output logic [15:0]   ld_cnt,
  output logic [15:0]   st_cnt
);

  ms_state_e state;
  logic [AW-1:0] ptr;

  logic [NUM_LANES-1:0][VEC_W-1:0] mem [DEPTH];

  logic [AW-1:0]                   widx;
  logic [1:0]                      off;
  logic                            oor, is_ld, is_st, mis_ld, mis_st, exc, acc, st_we;
  logic [NUM_LANES-1:0]            be;
  logic [NUM_LANES-1:0][VEC_W-1:0] wdata;
  logic [31:0]                     rword, ld_data;

  assign off   = ex_alu[1:0];
  assign widx  = ex_alu[AW+1:2];
  assign oor   = |ex_alu[31:AW+2];
  // read+write together behaves as a store with no writeback
  assign is_st = ex_mem_write;
  assign is_ld = ex_mem_read & ~ex_mem_write;

  assign rword    = mem[widx];
  assign dbg_data = mem[dbg_addr];

  load_align u_align (
    .word     (rword),
    .off      (off),
    .funct3   (ex_funct3),
    .data     (ld_data),
    .misalign (mis_ld)
  );

  always_comb begin
    be     = '0;
    wdata  = ex_store_data;
    mis_st = 1'b0;
    case (ex_funct3)
      FUNCT3_SB: begin
        be    = NUM_LANES'(1) << off;
        wdata = {4{ex_store_data[7:0]}};
      end
      FUNCT3_SH: begin
        be     = NUM_LANES'(3) << off;
        wdata  = {2{ex_store_data[15:0]}};
        mis_st = off[0];
      end
      FUNCT3_SW: begin
        be     = '1;
        mis_st = |off;
      end
      default: mis_st = 1'b1;
    endcase
  end

  assign exc      = (is_ld & (oor | mis_ld)) | (is_st & (oor | mis_st));
  assign ex_ready = (state == MS_RUN) & (~wb_stall | ~wb_valid);
  assign acc      = ex_valid & ex_ready & ~ex_flush;
  assign st_we    = acc & is_st & ~exc;

  // RAM has no reset; the CLEAR sweep zeroes it after every reset
  always_ff @(posedge clk) begin
    if (state == MS_CLEAR) begin
      mem[ptr] <= '0;
    end else if (st_we) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (be[i]) mem[widx][i] <= wdata[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= MS_CLEAR;
      ptr   <= '0;
    end else if (state == MS_CLEAR) begin
      ptr <= ptr + AW'(1);
      if (ptr == AW'(DEPTH - 1)) state <= MS_RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exc       <= 1'b0;
      ld_cnt       <= '0;
      st_cnt       <= '0;
    end else if (ex_ready) begin
      if (acc) begin
        wb_valid     <= 1'b1;
        wb_rd        <= ex_rd;
        wb_exc       <= exc;
        wb_reg_write <= ex_reg_write & (ex_rd != 5'd0) & ~exc & ~is_st;
        wb_data      <= (is_ld & ~exc) ? ld_data : ex_alu;
        if (is_ld & ~exc) ld_cnt <= ld_cnt + 16'd1;
        if (is_st & ~exc) st_cnt <= st_cnt + 16'd1;
      end else begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: clear sweep, byte lanes, misalignment, stall/flush, reset mid-clear.
module tb_mem_stage;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ex_valid, ex_ready, ex_flush;
  logic [31:0]   ex_alu, ex_store_data;
  logic [2:0]    ex_funct3;
  logic          ex_mem_read, ex_mem_write, ex_reg_write;
  logic [4:0]    ex_rd;
  logic          wb_stall, wb_valid, wb_reg_write, wb_exc;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data, dbg_data;
  logic [AW-1:0] dbg_addr;
  logic [15:0]   ld_cnt, st_cnt;

  mem_stage #(.DEPTH(64), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .ex_alu(ex_alu), .ex_store_data(ex_store_data), .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .wb_stall(wb_stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .ld_cnt(ld_cnt), .st_cnt(st_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        rde, wre, rgw, fl;
    logic [4:0]  rd;
    logic [31:0] alu, sd, edata;
    logic        eexc, eregw, cd;
  } stim_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc, regw, cd;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] ld_exp = 0;
  logic [15:0] st_exp = 0;

  task automatic send(input stim_t s);
    int n = 0;
    @(negedge clk);
    while (!ex_ready && n < 200) begin @(negedge clk); n++; end
    if (!ex_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: ex_ready=%b after %0d cycles, expected 1", ex_ready, n);
    end
    ex_valid = 1'b1; ex_funct3 = s.f3; ex_mem_read = s.rde; ex_mem_write = s.wre;
    ex_reg_write = s.rgw; ex_flush = s.fl; ex_rd = s.rd; ex_alu = s.alu; ex_store_data = s.sd;
    if (!s.fl) begin
      q.push_back('{s.rd, s.edata, s.eexc, s.eregw, s.cd});
      if (!s.eexc && s.wre) st_exp++;
      else if (!s.eexc && s.rde) ld_exp++;
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_flush = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    int cnt = 0;
    while (!ex_ready && cnt < 200) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("FAIL %s: ex_ready low for %0d cycles, expected 64", name, cnt);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; ex_valid = 0; ex_flush = 0; ex_alu = 0; ex_store_data = 0; ex_funct3 = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_rd = 0; wb_stall = 0; dbg_addr = 0;
    #12;
    checks++;
    if ({wb_valid, wb_reg_write, wb_rd, wb_data, wb_exc, ex_ready, ld_cnt, st_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b regw=%b rd=%0d data=%h exc=%b ready=%b ld=%0d st=%0d, expected all 0",
               wb_valid, wb_reg_write, wb_rd, wb_data, wb_exc, ex_ready, ld_cnt, st_cnt);
    end
  endtask

  task automatic test_clear;
    @(negedge clk); rstn = 1'b1;
    wait_clear("clear_len");
    dbg_addr = 6'd5; #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++; $display("FAIL clear_dbg5: dbg_data=%h expected 00000000", dbg_data);
    end
  endtask

  task automatic test_byte;
    stim_t t[8];
    exp_t  e;
    t[0] = '{3'd2, 0, 1, 0, 0, 5'd0,  32'h10, 32'h80FF7F01, 32'h0,        0, 0, 0};
    t[1] = '{3'd0, 1, 0, 1, 0, 5'd5,  32'h13, 32'h0,        32'hFFFFFF80, 0, 1, 1};
    t[2] = '{3'd4, 1, 0, 1, 0, 5'd6,  32'h13, 32'h0,        32'h00000080, 0, 1, 1};
    t[3] = '{3'd1, 1, 0, 1, 0, 5'd7,  32'h12, 32'h0,        32'hFFFF80FF, 0, 1, 1};
    t[4] = '{3'd5, 1, 0, 1, 0, 5'd8,  32'h12, 32'h0,        32'h000080FF, 0, 1, 1};
    t[5] = '{3'd2, 1, 0, 1, 0, 5'd9,  32'h10, 32'h0,        32'h80FF7F01, 0, 1, 1};
    t[6] = '{3'd0, 1, 0, 1, 0, 5'd10, 32'h11, 32'h0,        32'h0000007F, 0, 1, 1};
    t[7] = '{3'd1, 1, 0, 1, 0, 5'd11, 32'h10, 32'h0,        32'h00007F01, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      send(t[i]);
      e = q.pop_front();
      checks++;
      if ({wb_valid, wb_rd, wb_exc, wb_reg_write} !== {1'b1, e.rd, e.exc, e.regw} || (e.cd && wb_data !== e.data)) begin
        errors++;
        $display("FAIL byte[%0d]: valid=%b rd=%0d exc=%b regw=%b data=%h, expected rd=%0d exc=%b regw=%b data=%h",
                 i, wb_valid, wb_rd, wb_exc, wb_reg_write, wb_data, e.rd, e.exc, e.regw, e.data);
      end
    end
    checks++;
    if (ld_cnt !== ld_exp || st_cnt !== st_exp) begin
      errors++; $display("FAIL byte_cnt: ld=%0d st=%0d, expected ld=%0d st=%0d", ld_cnt, st_cnt, ld_exp, st_exp);
    end
  endtask

  task automatic test_lane;
    stim_t t[3];
    exp_t  e;
    t[0] = '{3'd2, 0, 1, 0, 0, 5'd0, 32'h20, 32'h11223344, 32'h0,        0, 0, 0};
    t[1] = '{3'd0, 0, 1, 0, 0, 5'd0, 32'h21, 32'hDEADBEAA, 32'h0,        0, 0, 0};
    t[2] = '{3'd2, 1, 0, 1, 0, 5'd1, 32'h20, 32'h0,        32'h1122AA44, 0, 1, 1};
    for (int i = 0; i < 3; i++) begin
      send(t[i]);
      e = q.pop_front();
      checks++;
      if ({wb_valid, wb_rd, wb_exc, wb_reg_write} !== {1'b1, e.rd, e.exc, e.regw} || (e.cd && wb_data !== e.data)) begin
        errors++;
        $display("FAIL lane[%0d]: valid=%b rd=%0d exc=%b regw=%b data=%h, expected rd=%0d exc=%b regw=%b data=%h",
                 i, wb_valid, wb_rd, wb_exc, wb_reg_write, wb_data, e.rd, e.exc, e.regw, e.data);
      end
    end
    dbg_addr = 6'd8; #1;
    checks++;
    if (dbg_data !== 32'h1122AA44) begin
      errors++; $display("FAIL lane_dbg8: dbg_data=%h expected 1122aa44", dbg_data);
    end
    checks++;
    if (st_cnt !== st_exp) begin
      errors++; $display("FAIL lane_stcnt: st_cnt=%0d expected %0d", st_cnt, st_exp);
    end
  endtask

  task automatic test_misalign;
    stim_t t[6];
    exp_t  e;
    t[0] = '{3'd2, 1, 0, 1, 0, 5'd4, 32'h22,        32'h0,        32'h0, 1, 0, 0};
    t[1] = '{3'd1, 0, 1, 0, 0, 5'd0, 32'h05,        32'h0000BEEF, 32'h0, 1, 0, 0};
    t[2] = '{3'd1, 1, 0, 1, 0, 5'd4, 32'h21,        32'h0,        32'h0, 1, 0, 0};
    t[3] = '{3'd2, 1, 0, 1, 0, 5'd4, 32'h100,       32'h0,        32'h0, 1, 0, 0};
    t[4] = '{3'd3, 1, 0, 1, 0, 5'd4, 32'h20,        32'h0,        32'h0, 1, 0, 0};
    t[5] = '{3'd2, 0, 1, 0, 0, 5'd0, 32'h10000004,  32'hFFFFFFFF, 32'h0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      send(t[i]);
      e = q.pop_front();
      checks++;
      if ({wb_valid, wb_rd, wb_exc, wb_reg_write} !== {1'b1, e.rd, e.exc, e.regw}) begin
        errors++;
        $display("FAIL misalign[%0d]: valid=%b rd=%0d exc=%b regw=%b, expected rd=%0d exc=%b regw=%b",
                 i, wb_valid, wb_rd, wb_exc, wb_reg_write, e.rd, e.exc, e.regw);
      end
    end
    dbg_addr = 6'd1; #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++; $display("FAIL misalign_dbg1: dbg_data=%h expected 00000000", dbg_data);
    end
    checks++;
    if (ld_cnt !== ld_exp || st_cnt !== st_exp) begin
      errors++; $display("FAIL misalign_cnt: ld=%0d st=%0d, expected ld=%0d st=%0d", ld_cnt, st_cnt, ld_exp, st_exp);
    end
  endtask

  task automatic test_back_to_back;
    stim_t t[10];
    exp_t  e;
    t[0] = '{3'd2, 0, 1, 0, 0, 5'd0,  32'h3C,       32'hA5A55A5A, 32'h0,        0, 0, 0};
    t[1] = '{3'd2, 1, 0, 1, 0, 5'd2,  32'h3C,       32'h0,        32'hA5A55A5A, 0, 1, 1};
    t[2] = '{3'd1, 0, 1, 0, 0, 5'd0,  32'h3E,       32'hFFFF1234, 32'h0,        0, 0, 0};
    t[3] = '{3'd5, 1, 0, 1, 0, 5'd3,  32'h3E,       32'h0,        32'h00001234, 0, 1, 1};
    t[4] = '{3'd2, 1, 0, 1, 0, 5'd3,  32'h3C,       32'h0,        32'h12345A5A, 0, 1, 1};
    t[5] = '{3'd0, 0, 1, 0, 0, 5'd0,  32'h3C,       32'h00000077, 32'h0,        0, 0, 0};
    t[6] = '{3'd4, 1, 0, 1, 0, 5'd13, 32'h3C,       32'h0,        32'h00000077, 0, 1, 1};
    t[7] = '{3'd2, 1, 1, 1, 0, 5'd9,  32'hF8,       32'h01020304, 32'h0,        0, 0, 0};
    t[8] = '{3'd2, 1, 0, 1, 0, 5'd14, 32'hF8,       32'h0,        32'h01020304, 0, 1, 1};
    t[9] = '{3'd0, 0, 0, 1, 0, 5'd12, 32'hDEAD0001, 32'h0,        32'hDEAD0001, 0, 1, 1};
    for (int i = 0; i < 10; i++) begin
      send(t[i]);
      e = q.pop_front();
      checks++;
      if ({wb_valid, wb_rd, wb_exc, wb_reg_write} !== {1'b1, e.rd, e.exc, e.regw} || (e.cd && wb_data !== e.data)) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b rd=%0d exc=%b regw=%b data=%h, expected rd=%0d exc=%b regw=%b data=%h",
                 i, wb_valid, wb_rd, wb_exc, wb_reg_write, wb_data, e.rd, e.exc, e.regw, e.data);
      end
    end
    checks++;
    if (ld_cnt !== ld_exp || st_cnt !== st_exp) begin
      errors++; $display("FAIL b2b_cnt: ld=%0d st=%0d, expected ld=%0d st=%0d", ld_cnt, st_cnt, ld_exp, st_exp);
    end
  endtask

  task automatic test_stall_flush;
    exp_t e;
    send('{3'd0, 0, 0, 1, 0, 5'd3, 32'h1234, 32'h0, 32'h1234, 0, 1, 1});
    e = q.pop_front();
    checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, e.rd, e.data}) begin
      errors++; $display("FAIL stall_pre: valid=%b rd=%0d data=%h, expected rd=%0d data=%h", wb_valid, wb_rd, wb_data, e.rd, e.data);
    end
    @(negedge clk);
    wb_stall = 1'b1; ex_valid = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd4; ex_alu = 32'h5555; ex_funct3 = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({ex_ready, wb_valid, wb_rd, wb_data} !== {1'b0, 1'b1, 5'd3, 32'h1234}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: ready=%b valid=%b rd=%0d data=%h, expected ready=0 valid=1 rd=3 data=00001234",
                 k, ex_ready, wb_valid, wb_rd, wb_data);
      end
    end
    @(negedge clk);
    wb_stall = 1'b0;
    q.push_back('{5'd4, 32'h5555, 1'b0, 1'b1, 1'b1});
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_reg_write = 1'b0;
    e = q.pop_front();
    checks++;
    if ({wb_valid, wb_rd, wb_reg_write, wb_data} !== {1'b1, e.rd, e.regw, e.data}) begin
      errors++; $display("FAIL stall_release: valid=%b rd=%0d regw=%b data=%h, expected rd=%0d data=%h",
                         wb_valid, wb_rd, wb_reg_write, wb_data, e.rd, e.data);
    end
    send('{3'd2, 0, 1, 0, 1, 5'd0, 32'h30, 32'hCAFEBABE, 32'h0, 0, 0, 0});
    dbg_addr = 6'd12; #1;
    checks++;
    if ({wb_valid, dbg_data, st_cnt} !== {1'b0, 32'h0, st_exp}) begin
      errors++; $display("FAIL flush: valid=%b dbg12=%h st=%0d, expected valid=0 dbg12=00000000 st=%0d",
                         wb_valid, dbg_data, st_cnt, st_exp);
    end
    send('{3'd0, 0, 0, 1, 0, 5'd1, 32'h99, 32'h0, 32'h99, 0, 1, 1});
    e = q.pop_front();
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL idle: wb_valid=%b expected 0 (after rd=%0d)", wb_valid, e.rd);
    end
    wb_stall = 1'b1; #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++; $display("FAIL stall_empty: ex_ready=%b expected 1", ex_ready);
    end
    wb_stall = 1'b0;
  endtask

  task automatic test_reset_mid_clear;
    exp_t e;
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    repeat (20) @(posedge clk);
    #3 rstn = 1'b0; ld_exp = 0; st_exp = 0;
    #1;
    checks++;
    if ({ex_ready, wb_valid, ld_cnt, st_cnt} !== '0) begin
      errors++; $display("FAIL midclear_reset: ready=%b valid=%b ld=%0d st=%0d, expected all 0",
                         ex_ready, wb_valid, ld_cnt, st_cnt);
    end
    @(negedge clk); rstn = 1'b1;
    wait_clear("midclear_len");
    dbg_addr = 6'd15; #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++; $display("FAIL midclear_dbg15: dbg_data=%h expected 00000000", dbg_data);
    end
    dbg_addr = 6'd62; #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++; $display("FAIL midclear_dbg62: dbg_data=%h expected 00000000", dbg_data);
    end
    send('{3'd0, 0, 0, 1, 0, 5'd0, 32'h7, 32'h0, 32'h7, 0, 0, 1});
    e = q.pop_front();
    checks++;
    if ({wb_valid, wb_rd, wb_reg_write, wb_exc, wb_data} !== {1'b1, e.rd, e.regw, e.exc, e.data}) begin
      errors++; $display("FAIL rd0: valid=%b rd=%0d regw=%b exc=%b data=%h, expected regw=0 data=%h",
                         wb_valid, wb_rd, wb_reg_write, wb_exc, wb_data, e.data);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte();
    test_lane();
    test_misalign();
    test_back_to_back();
    test_stall_flush();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
